// File: rtl/vproc_vreg_wr_arbiter_if.sv
// Requester handshake and register-file write-port bus of vproc_vreg_wr_arbiter.
// wr_pend_o exists only when VPROC_VREG_WR_PEND_EN is defined.
interface vproc_vreg_wr_arbiter_if #(
  parameter int VREG_W   = 128,
  parameter int PORT_W   = 128,
  parameter int PORTS_WR = 2,
  parameter int REQ_CNT  = 4
);
  localparam int ADDR_W = 5 + $clog2(VREG_W / PORT_W);

  logic [REQ_CNT-1:0]                 req_valid_i;
  logic [REQ_CNT-1:0]                 req_ready_o;
  logic [REQ_CNT-1:0][ADDR_W-1:0]     req_addr_i;
  logic [REQ_CNT-1:0][PORT_W-1:0]     req_data_i;
  logic [REQ_CNT-1:0][PORT_W/8-1:0]   req_be_i;

  logic [PORTS_WR-1:0]                wr_we_o;
  logic [PORTS_WR-1:0][ADDR_W-1:0]    wr_addr_o;
  logic [PORTS_WR-1:0][PORT_W-1:0]    wr_data_o;
  logic [PORTS_WR-1:0][PORT_W/8-1:0]  wr_be_o;
`ifdef VPROC_VREG_WR_PEND_EN
  logic [31:0]                        wr_pend_o;
`endif

  modport slave (
    input  req_valid_i, req_addr_i, req_data_i, req_be_i,
    output req_ready_o, wr_we_o, wr_addr_o, wr_data_o, wr_be_o
`ifdef VPROC_VREG_WR_PEND_EN
    , wr_pend_o
`endif
  );

  modport master (
    output req_valid_i, req_addr_i, req_data_i, req_be_i,
    input  req_ready_o, wr_we_o, wr_addr_o, wr_data_o, wr_be_o
`ifdef VPROC_VREG_WR_PEND_EN
    , wr_pend_o
`endif
  );
endinterface

// File: rtl/vproc_vreg_wr_arbiter.sv
// Round-robin arbiter sharing the XOR regfile write ports, with same-address suppression.
// Define VPROC_VREG_WR_PEND_EN to add the per-vreg in-flight write mask wr_pend_o.
module vproc_vreg_wr_arbiter #(
  parameter int VREG_W   = 128,
  parameter int PORT_W   = 128,
  parameter int PORTS_WR = 2,
  parameter int REQ_CNT  = 4
) (
  input  logic                   clk_i,
  input  logic                   async_rst_ni,
  vproc_vreg_wr_arbiter_if.slave bus
);
  localparam int ADDR_W = 5 + $clog2(VREG_W / PORT_W);
  localparam int RR_W   = (REQ_CNT > 1) ? $clog2(REQ_CNT) : 1;

  logic [RR_W-1:0]                   rr_q, rr_d;
  logic [REQ_CNT-1:0]                gnt;
  logic [PORTS_WR-1:0]               port_vld;
  logic [PORTS_WR-1:0][ADDR_W-1:0]   port_addr;
  logic [PORTS_WR-1:0][PORT_W-1:0]   port_data;
  logic [PORTS_WR-1:0][PORT_W/8-1:0] port_be;

  always_comb begin : arb_comb
    int  slot;
    int  n_gnt;
    logic conflict;
    gnt       = '0;
    port_vld  = '0;
    port_addr = '0;
    port_data = '0;
    port_be   = '0;
    rr_d      = rr_q;
    n_gnt     = 0;
    slot      = 0;
    conflict  = 1'b0;
    for (int i = 0; i < REQ_CNT; i++) begin
      slot = int'(rr_q) + i;
      if (slot >= REQ_CNT) slot = slot - REQ_CNT;
      for (int k = 0; k < REQ_CNT; k++) begin
        if (k == slot) begin
          // ports fill in scan order, so port_vld marks exactly the addresses taken so far
          conflict = 1'b0;
          for (int p = 0; p < PORTS_WR; p++) begin
            if (port_vld[p] && (port_addr[p] == bus.req_addr_i[k])) conflict = 1'b1;
          end
          if (bus.req_valid_i[k] && (n_gnt < PORTS_WR) && !conflict) begin
            gnt[k] = 1'b1;
            for (int p = 0; p < PORTS_WR; p++) begin
              if (p == n_gnt) begin
                port_vld[p]  = 1'b1;
                port_addr[p] = bus.req_addr_i[k];
                port_data[p] = bus.req_data_i[k];
                port_be[p]   = bus.req_be_i[k];
              end
            end
            n_gnt = n_gnt + 1;
            rr_d  = (k == REQ_CNT - 1) ? '0 : RR_W'(k + 1);
          end
        end
      end
    end
  end

  assign bus.req_ready_o = gnt;

`ifdef VPROC_VREG_WR_PEND_EN
  logic [31:0] pend_d;

  always_comb begin
    pend_d = '0;
    for (int p = 0; p < PORTS_WR; p++) begin
      if (port_vld[p]) pend_d[port_addr[p][ADDR_W-1 -: 5]] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge async_rst_ni) begin
    if (!async_rst_ni) bus.wr_pend_o <= '0;
    else               bus.wr_pend_o <= pend_d;
  end
`endif

  // no back-pressure from the regfile: the output stage advances every cycle
  always_ff @(posedge clk_i or negedge async_rst_ni) begin
    if (!async_rst_ni) begin
      rr_q          <= '0;
      bus.wr_we_o   <= '0;
      bus.wr_addr_o <= '0;
      bus.wr_data_o <= '0;
      bus.wr_be_o   <= '0;
    end else begin
      rr_q        <= rr_d;
      bus.wr_we_o <= port_vld;
      for (int p = 0; p < PORTS_WR; p++) begin
        if (port_vld[p]) begin
          bus.wr_addr_o[p] <= port_addr[p];
          bus.wr_data_o[p] <= port_data[p];
          bus.wr_be_o[p]   <= port_be[p];
        end
      end
    end
  end
endmodule

// File: tb/tb_vproc_vreg_wr_arbiter.sv
// Self-checking bench for vproc_vreg_wr_arbiter: directed scenarios plus random traffic
// against a queue-based round-robin model. Covers wr_pend_o when VPROC_VREG_WR_PEND_EN is set.
module tb_vproc_vreg_wr_arbiter;
  localparam int REQ = 4;
  localparam int PW  = 2;
  localparam int VW  = 128;
  localparam int DW  = 128;
  localparam int BW  = DW / 8;
  localparam int AW  = 5;

  logic clk_i = 1'b0;
  logic async_rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  vproc_vreg_wr_arbiter_if #(.VREG_W(VW), .PORT_W(DW), .PORTS_WR(PW), .REQ_CNT(REQ)) bus ();

  vproc_vreg_wr_arbiter #(.VREG_W(VW), .PORT_W(DW), .PORTS_WR(PW), .REQ_CNT(REQ)) dut (
    .clk_i       (clk_i),
    .async_rst_ni(async_rst_ni),
    .bus         (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [REQ-1:0] v;
  logic [AW-1:0]  a [REQ];
  logic [DW-1:0]  d [REQ];
  logic [BW-1:0]  b [REQ];

  int             m_rr;
  logic [REQ-1:0] m_gnt;
  int             m_ports[$];
  logic [PW-1:0]          e_we;
  logic [PW-1:0][AW-1:0]  e_addr;
  logic [PW-1:0][DW-1:0]  e_data;
  logic [PW-1:0][BW-1:0]  e_be;
`ifdef VPROC_VREG_WR_PEND_EN
  logic [31:0]            e_pend;
`endif

  task automatic model_reset();
    m_rr = 0;
    m_gnt = '0;
    m_ports.delete();
    e_we = '0; e_addr = '0; e_data = '0; e_be = '0;
`ifdef VPROC_VREG_WR_PEND_EN
    e_pend = '0;
`endif
  endtask

  // Drive requester state, then work out this cycle's grants from the arbitration rules.
  task automatic eval();
    int taken[$];
    bit dup;
    int k;
    bus.req_valid_i = v;
    for (int i = 0; i < REQ; i++) begin
      bus.req_addr_i[i] = a[i];
      bus.req_data_i[i] = d[i];
      bus.req_be_i[i]   = b[i];
    end
    m_gnt = '0;
    m_ports.delete();
    for (int n = 0; n < REQ; n++) begin
      k = (m_rr + n) % REQ;
      dup = 1'b0;
      foreach (taken[j]) if (taken[j] == int'(a[k])) dup = 1'b1;
      if (v[k] && m_ports.size() < PW && !dup) begin
        m_gnt[k] = 1'b1;
        m_ports.push_back(k);
        taken.push_back(int'(a[k]));
      end
    end
    #1;
  endtask

  // Clock edge; expected output stage follows from the grants computed by eval().
  task automatic tick();
    @(posedge clk_i);
    #1;
    if (m_ports.size() > 0) m_rr = (m_ports[m_ports.size()-1] + 1) % REQ;
    e_we = '0;
`ifdef VPROC_VREG_WR_PEND_EN
    e_pend = '0;
`endif
    foreach (m_ports[p]) begin
      e_we[p]   = 1'b1;
      e_addr[p] = a[m_ports[p]];
      e_data[p] = d[m_ports[p]];
      e_be[p]   = b[m_ports[p]];
`ifdef VPROC_VREG_WR_PEND_EN
      e_pend[a[m_ports[p]]] = 1'b1;
`endif
    end
  endtask

  task automatic new_req(input int k, input int amax);
    v[k] = ($urandom % 4) != 0;
    a[k] = AW'($urandom_range(0, amax));
    d[k] = {$urandom, $urandom, $urandom, $urandom};
    b[k] = (($urandom % 5) == 0) ? '0 : BW'($urandom);
  endtask

  task automatic test_reset();
    v = '0;
    for (int i = 0; i < REQ; i++) begin a[i] = '0; d[i] = '0; b[i] = '0; end
    model_reset();
    eval();
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    async_rst_ni = 1'b1;
    #1;
    total++;
    if ({bus.wr_we_o, bus.wr_addr_o, bus.wr_be_o} !== '0 || bus.wr_data_o !== '0) begin
      bad++;
      $display("FAIL reset_outputs: we=%b addr=%h be=%h, need all zero", bus.wr_we_o, bus.wr_addr_o, bus.wr_be_o);
    end
    for (int c = 0; c < 10; c++) begin
      eval();
      tick();
      total++;
      if (bus.wr_we_o !== 2'b00 || bus.req_ready_o !== 4'b0000 || dut.rr_q !== 2'd0) begin
        bad++;
        $display("FAIL reset_idle c%0d: we=%b ready=%b rr=%0d, need 00 0000 0", c, bus.wr_we_o, bus.req_ready_o, dut.rr_q);
      end
    end
`ifdef VPROC_VREG_WR_PEND_EN
    total++;
    if (bus.wr_pend_o !== 32'h0) begin bad++; $display("FAIL reset_pend: got %h need 0", bus.wr_pend_o); end
`endif
  endtask

  task automatic test_basic();
    v = 4'b1111;
    a[0] = 5'd3; a[1] = 5'd5; a[2] = 5'd7; a[3] = 5'd9;
    for (int i = 0; i < REQ; i++) begin d[i] = {4{32'hA000_0000 + i}}; b[i] = BW'(16'h1111 << i); end
    eval();
    total++;
    if (bus.req_ready_o !== 4'b0011) begin bad++; $display("FAIL basic_ready0: got %b need 0011", bus.req_ready_o); end
    tick();
    total++;
    if (bus.wr_we_o !== 2'b11 || bus.wr_addr_o[0] !== 5'd3 || bus.wr_addr_o[1] !== 5'd5 ||
        bus.wr_data_o[1] !== {4{32'hA000_0001}} || bus.wr_be_o[0] !== 16'h1111) begin
      bad++;
      $display("FAIL basic_out0: we=%b a0=%0d a1=%0d, need 11 3 5 with req0/req1 data", bus.wr_we_o, bus.wr_addr_o[0], bus.wr_addr_o[1]);
    end
    v[0] = 1'b0; v[1] = 1'b0;
    eval();
    total++;
    if (bus.req_ready_o !== 4'b1100) begin bad++; $display("FAIL basic_ready1: got %b need 1100", bus.req_ready_o); end
    tick();
    total++;
    if (bus.wr_we_o !== 2'b11 || bus.wr_addr_o[0] !== 5'd7 || bus.wr_addr_o[1] !== 5'd9 ||
        bus.wr_data_o[0] !== {4{32'hA000_0002}} || bus.wr_be_o[1] !== 16'h8888) begin
      bad++;
      $display("FAIL basic_out1: we=%b a0=%0d a1=%0d, need 11 7 9 with req2/req3 data", bus.wr_we_o, bus.wr_addr_o[0], bus.wr_addr_o[1]);
    end
    v = '0;
  endtask

  task automatic test_conflict();
    v = 4'b1010;
    a[1] = 5'd6; a[3] = 5'd6;
    d[1] = {4{32'h1111_1111}}; d[3] = {4{32'h3333_3333}};
    eval();
    total++;
    if (bus.req_ready_o !== 4'b0010) begin bad++; $display("FAIL conflict_ready0: got %b need 0010", bus.req_ready_o); end
    tick();
    total++;
    if (bus.wr_we_o !== 2'b01 || bus.wr_addr_o[0] !== 5'd6 || bus.wr_data_o[0] !== {4{32'h1111_1111}}) begin
      bad++;
      $display("FAIL conflict_out0: we=%b a0=%0d, need 01 6 with req1 data", bus.wr_we_o, bus.wr_addr_o[0]);
    end
    v[1] = 1'b0;
    eval();
    total++;
    if (bus.req_ready_o !== 4'b1000) begin bad++; $display("FAIL conflict_ready1: got %b need 1000", bus.req_ready_o); end
    tick();
    total++;
    if (bus.wr_we_o !== 2'b01 || bus.wr_addr_o[0] !== 5'd6 || bus.wr_data_o[0] !== {4{32'h3333_3333}}) begin
      bad++;
      $display("FAIL conflict_out1: we=%b a0=%0d, need 01 6 with req3 data", bus.wr_we_o, bus.wr_addr_o[0]);
    end
    v = '0;
  endtask

  task automatic test_fairness();
    int cnt[REQ];
    int since[REQ];
    for (int i = 0; i < REQ; i++) begin cnt[i] = 0; since[i] = 0; a[i] = AW'(10 + i); end
    v = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      eval();
      for (int i = 0; i < REQ; i++) begin
        if (bus.req_ready_o[i]) begin cnt[i]++; since[i] = 0; end
        else since[i]++;
        total++;
        if (since[i] > 1) begin bad++; $display("FAIL fair_wait c%0d r%0d: waited %0d cycles, limit 1", c, i, since[i]); end
      end
      tick();
      for (int i = 0; i < REQ; i++) if (m_gnt[i]) d[i] = {$urandom, $urandom, $urandom, $urandom};
    end
    for (int i = 0; i < REQ; i++) begin
      total++;
      if (cnt[i] != 4) begin bad++; $display("FAIL fair_count r%0d: accepted %0d need 4", i, cnt[i]); end
    end
    v = '0;
  endtask

  task automatic test_random();
    for (int i = 0; i < REQ; i++) new_req(i, 7);
    for (int c = 0; c < 300; c++) begin
      eval();
      total++;
      if (bus.req_ready_o !== m_gnt) begin bad++; $display("FAIL rand_ready c%0d: got %b need %b", c, bus.req_ready_o, m_gnt); end
      tick();
      total++;
      if (bus.wr_we_o !== e_we || bus.wr_addr_o !== e_addr || bus.wr_data_o !== e_data || bus.wr_be_o !== e_be) begin
        bad++;
        $display("FAIL rand_out c%0d: we=%b addr=%h be=%h need we=%b addr=%h be=%h", c, bus.wr_we_o, bus.wr_addr_o, bus.wr_be_o, e_we, e_addr, e_be);
      end
`ifdef VPROC_VREG_WR_PEND_EN
      total++;
      if (bus.wr_pend_o !== e_pend) begin bad++; $display("FAIL rand_pend c%0d: got %h need %h", c, bus.wr_pend_o, e_pend); end
`endif
      for (int i = 0; i < REQ; i++) if (m_gnt[i] || !v[i]) new_req(i, 7);
    end
    v = '0;
  endtask

  task automatic test_reset_mid();
    v = 4'b1111;
    for (int i = 0; i < REQ; i++) a[i] = AW'(20 + i);
    eval();
    tick();
    total++;
    if (bus.wr_we_o !== 2'b11) begin bad++; $display("FAIL midrst_pre: we=%b need 11", bus.wr_we_o); end
    #1 async_rst_ni = 1'b0;
    #1;
    total++;
    if (bus.wr_we_o !== 2'b00 || bus.wr_addr_o !== '0 || bus.wr_data_o !== '0 || dut.rr_q !== 2'd0) begin
      bad++;
      $display("FAIL midrst_clear: we=%b addr=%h rr=%0d need 00 0 0", bus.wr_we_o, bus.wr_addr_o, dut.rr_q);
    end
    v = '0;
    model_reset();
    eval();
    @(negedge clk_i);
    async_rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    total++;
    if (dut.rr_q !== 2'd0 || bus.wr_we_o !== 2'b00) begin bad++; $display("FAIL midrst_idle: rr=%0d we=%b need 0 00", dut.rr_q, bus.wr_we_o); end
    v[2] = 1'b1; a[2] = 5'd1; d[2] = {4{32'h2222_2222}}; b[2] = 16'hFFFF;
    eval();
    total++;
    if (bus.req_ready_o !== 4'b0100) begin bad++; $display("FAIL midrst_ready: got %b need 0100", bus.req_ready_o); end
    tick();
    total++;
    if (bus.wr_we_o !== 2'b01 || bus.wr_addr_o[0] !== 5'd1 || bus.wr_data_o[0] !== {4{32'h2222_2222}}) begin
      bad++;
      $display("FAIL midrst_out: we=%b a0=%0d need 01 1", bus.wr_we_o, bus.wr_addr_o[0]);
    end
    v = '0;
  endtask

`ifdef VPROC_VREG_WR_PEND_EN
  task automatic test_pend();
    v = 4'b0001; a[0] = 5'd17; b[0] = 16'h00FF;
    eval();
    tick();
    total++;
    if (bus.wr_pend_o !== 32'h0002_0000 || bus.wr_we_o !== 2'b01) begin
      bad++;
      $display("FAIL pend_set: pend=%h we=%b need 00020000 01", bus.wr_pend_o, bus.wr_we_o);
    end
    v = '0;
    eval();
    tick();
    total++;
    if (bus.wr_pend_o !== 32'h0 || bus.wr_we_o !== 2'b00) begin
      bad++;
      $display("FAIL pend_clear: pend=%h we=%b need 0 00", bus.wr_pend_o, bus.wr_we_o);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_conflict();
    test_fairness();
    test_random();
    test_reset_mid();
`ifdef VPROC_VREG_WR_PEND_EN
    test_pend();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
